// File: rtl/race_sequencer.sv
// race_sequencer: race-flow controller for the Drag-Racing game.
// Sequences IDLE -> COUNTDOWN (start lights) -> RACE -> FINISHED, gates both
// players' controllers/timers, flags false starts, latches finish order and
// raises end-of-game for the scoreboard.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   ms_tick               1 ms strobe driving the start-light countdown
//   start_req             menu level requesting a new game
//   restart_tick          pulse returning to the menu from any active phase
//   p1_key, p2_key        throttle key levels (false-start detection)
//   p1_position, p2_position  unsigned player positions
//   state, lights, race_go, p1_enable, p2_enable, timers_restart,
//   p1_false_start, p2_false_start, p1_finished, p2_finished,
//   end_game, winner      registered status/control outputs
module race_sequencer #(
    parameter int unsigned FINISH_LINE_POS = 2000,
    parameter int unsigned LIGHTS          = 5,
    parameter int unsigned LIGHT_PERIOD_MS = 1000,
    parameter int unsigned POS_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ms_tick,
    input  logic                 start_req,
    input  logic                 restart_tick,
    input  logic                 p1_key,
    input  logic                 p2_key,
    input  logic [POS_WIDTH-1:0] p1_position,
    input  logic [POS_WIDTH-1:0] p2_position,
    output logic [1:0]           state,
    output logic [2:0]           lights,
    output logic                 race_go,
    output logic                 p1_enable,
    output logic                 p2_enable,
    output logic                 timers_restart,
    output logic                 p1_false_start,
    output logic                 p2_false_start,
    output logic                 p1_finished,
    output logic                 p2_finished,
    output logic                 end_game,
    output logic [1:0]           winner
);

    localparam int unsigned MS_W = (LIGHT_PERIOD_MS > 1) ? $clog2(LIGHT_PERIOD_MS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RACE      = 2'd2,
        S_FINISHED  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [2:0]      lights_q, lights_d;
    logic            p1_fs_q, p1_fs_d, p2_fs_q, p2_fs_d;
    logic            p1_fin_q, p1_fin_d, p2_fin_q, p2_fin_d;
    logic [1:0]      winner_q, winner_d;
    logic            race_go_q, race_go_d;
    logic            p1_en_q, p1_en_d, p2_en_q, p2_en_d;
    logic            tr_q, tr_d;
    logic            end_game_q, end_game_d;

    logic            abort_c;
    logic            light_step_c;
    logic            last_light_c;
    logic            p1_cross_c, p2_cross_c;

    assign abort_c      = restart_tick && (state_q != S_IDLE);
    assign light_step_c = ms_tick && (ms_cnt_q == MS_W'(LIGHT_PERIOD_MS - 1));
    assign last_light_c = light_step_c && (lights_q == 3'(LIGHTS - 1));
    assign p1_cross_c   = p1_position >= POS_WIDTH'(FINISH_LINE_POS);
    assign p2_cross_c   = p2_position >= POS_WIDTH'(FINISH_LINE_POS);

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ms_cnt_q   <= '0;
            lights_q   <= '0;
            p1_fs_q    <= 1'b0;
            p2_fs_q    <= 1'b0;
            p1_fin_q   <= 1'b0;
            p2_fin_q   <= 1'b0;
            winner_q   <= '0;
            race_go_q  <= 1'b0;
            p1_en_q    <= 1'b0;
            p2_en_q    <= 1'b0;
            tr_q       <= 1'b0;
            end_game_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_cnt_q   <= ms_cnt_d;
            lights_q   <= lights_d;
            p1_fs_q    <= p1_fs_d;
            p2_fs_q    <= p2_fs_d;
            p1_fin_q   <= p1_fin_d;
            p2_fin_q   <= p2_fin_d;
            winner_q   <= winner_d;
            race_go_q  <= race_go_d;
            p1_en_q    <= p1_en_d;
            p2_en_q    <= p2_en_d;
            tr_q       <= tr_d;
            end_game_q <= end_game_d;
        end
    end

    // Next-state logic; restart_tick overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_req && !restart_tick) state_d = S_COUNTDOWN;
            S_COUNTDOWN: if (last_light_c) state_d = S_RACE;
            S_RACE:      if (p1_fin_q && p2_fin_q) state_d = S_FINISHED;
            default:     ;
        endcase
        if (abort_c) state_d = S_IDLE;
    end

    // Datapath and registered-output next values
    always_comb begin
        ms_cnt_d = ms_cnt_q;
        lights_d = lights_q;
        p1_fs_d  = p1_fs_q;
        p2_fs_d  = p2_fs_q;
        p1_fin_d = p1_fin_q;
        p2_fin_d = p2_fin_q;
        winner_d = winner_q;
        tr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                ms_cnt_d = '0;
                lights_d = '0;
                p1_fs_d  = 1'b0;
                p2_fs_d  = 1'b0;
                p1_fin_d = 1'b0;
                p2_fin_d = 1'b0;
                winner_d = '0;
                tr_d     = start_req && !restart_tick;
            end
            S_COUNTDOWN: begin
                if (p1_key) p1_fs_d = 1'b1;
                if (p2_key) p2_fs_d = 1'b1;
                if (light_step_c) begin
                    ms_cnt_d = '0;
                    lights_d = 3'(lights_q + 3'd1);
                end else if (ms_tick) begin
                    ms_cnt_d = MS_W'(ms_cnt_q + MS_W'(1));
                end
                // A false-started player counts as finished from the first RACE cycle
                if (last_light_c) begin
                    p1_fin_d = p1_fs_d;
                    p2_fin_d = p2_fs_d;
                end
            end
            S_RACE: begin
                if (p1_cross_c) p1_fin_d = 1'b1;
                if (p2_cross_c) p2_fin_d = 1'b1;
                // Winner is zero until a qualified player finishes, then frozen;
                // bit 0 = P1, bit 1 = P2, both bits = tie
                if (winner_q == 2'd0) begin
                    winner_d = {p2_cross_c && !p2_fs_q, p1_cross_c && !p1_fs_q};
                end
            end
            default: ;
        endcase

        if (abort_c) begin
            ms_cnt_d = '0;
            lights_d = '0;
            p1_fs_d  = 1'b0;
            p2_fs_d  = 1'b0;
            p1_fin_d = 1'b0;
            p2_fin_d = 1'b0;
            winner_d = '0;
        end

        race_go_d  = (state_d == S_RACE);
        p1_en_d    = (state_d == S_RACE) && !p1_fin_d && !p1_fs_d;
        p2_en_d    = (state_d == S_RACE) && !p2_fin_d && !p2_fs_d;
        end_game_d = (state_d == S_FINISHED);
    end

    assign state          = state_q;
    assign lights         = lights_q;
    assign race_go        = race_go_q;
    assign p1_enable      = p1_en_q;
    assign p2_enable      = p2_en_q;
    assign timers_restart = tr_q;
    assign p1_false_start = p1_fs_q;
    assign p2_false_start = p2_fs_q;
    assign p1_finished    = p1_fin_q;
    assign p2_finished    = p2_fin_q;
    assign end_game       = end_game_q;
    assign winner         = winner_q;

endmodule
